// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared constants, state encoding and checksum fold for the UDP TX framer
package udp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CSUM,
    ST_HEADER,
    ST_PAYLOAD
  } state_t;

  localparam int          HDR_LEN        = 42;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [15:0] IP_FLAGS_FRAG  = 16'h4000;
  localparam logic [7:0]  IP_TTL         = 8'h40;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  // Two folds are enough for a sum of ten 16-bit words.
  function automatic logic [15:0] csum_fold(input logic [31:0] s);
    logic [31:0] t;
    t = {16'h0000, s[31:16]} + {16'h0000, s[15:0]};
    t = {16'h0000, t[31:16]} + {16'h0000, t[15:0]};
    return ~t[15:0];
  endfunction

endpackage

// File: rtl/ip_checksum.sv
// rtl/ip_checksum.sv - two-cycle IPv4 header checksum; only ident varies per frame
module ip_checksum
  import udp_pkg::*;
#(
  parameter logic [15:0] IP_LEN = 16'd1052,
  parameter logic [31:0] SRC_IP = 32'hC0A8010A,
  parameter logic [31:0] DST_IP = 32'hC0A80101
) (
  input  logic        tx_clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [15:0] ident,
  output logic [15:0] csum
);

  localparam logic [31:0] BASE_SUM =
      {16'h0000, IP_VER_IHL, 8'h00} + {16'h0000, IP_LEN} + {16'h0000, IP_FLAGS_FRAG} +
      {16'h0000, IP_TTL, IP_PROTO_UDP} +
      {16'h0000, SRC_IP[31:16]} + {16'h0000, SRC_IP[15:0]} +
      {16'h0000, DST_IP[31:16]} + {16'h0000, DST_IP[15:0]};

  logic [31:0] sum_q;
  logic        sum_vld;

  always_ff @(posedge tx_clk) begin
    if (!rstn) begin
      sum_q   <= '0;
      sum_vld <= 1'b0;
      csum    <= '0;
    end else begin
      sum_vld <= start;
      if (start) sum_q <= BASE_SUM + {16'h0000, ident};
      if (sum_vld) csum <= csum_fold(sum_q);
    end
  end

endmodule

// File: rtl/udp_tx_framer.sv
// rtl/udp_tx_framer.sv - Ethernet/IPv4/UDP header generator with zero-latency payload pass-through
module udp_tx_framer
  import udp_pkg::*;
#(
  parameter int          PAYLOAD_LEN = 1024,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP      = 32'hC0A8010A,
  parameter logic [31:0] DST_IP      = 32'hC0A80101,
  parameter logic [15:0] SRC_PORT    = 16'd5000,
  parameter logic [15:0] DST_PORT    = 16'd5000
) (
  input  logic        tx_clk,
  input  logic        rstn,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        tx_err,
  output logic        tx_wren,
  input  logic        tx_rdy,
  output logic [15:0] pkt_count,
  output logic        busy
);

  localparam logic [15:0] IP_LEN   = 16'(28 + PAYLOAD_LEN);
  localparam logic [15:0] UDP_LEN  = 16'(8 + PAYLOAD_LEN);
  localparam logic [10:0] LAST_PAY = 11'(PAYLOAD_LEN - 1);
  localparam logic [5:0]  LAST_HDR = 6'(HDR_LEN - 1);

  state_t      state;
  logic        csum_phase;
  logic [5:0]  hdr_idx;
  logic [10:0] pay_idx;
  logic [15:0] ident;
  logic [15:0] ip_csum;
  logic [HDR_LEN-1:0][7:0] hdr;

  ip_checksum #(
    .IP_LEN (IP_LEN),
    .SRC_IP (SRC_IP),
    .DST_IP (DST_IP)
  ) u_csum (
    .tx_clk (tx_clk),
    .rstn   (rstn),
    .start  (state == ST_CSUM && !csum_phase),
    .ident  (ident),
    .csum   (ip_csum)
  );

  // Header byte 0 sits in the most significant element.
  assign hdr = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4, IP_VER_IHL, 8'h00, IP_LEN, ident,
                IP_FLAGS_FRAG, IP_TTL, IP_PROTO_UDP, ip_csum, SRC_IP, DST_IP,
                SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};

  always_ff @(posedge tx_clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      csum_phase <= 1'b0;
      hdr_idx    <= '0;
      pay_idx    <= '0;
      ident      <= '0;
      pkt_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state      <= ST_CSUM;
            csum_phase <= 1'b0;
          end
        end
        ST_CSUM: begin
          csum_phase <= 1'b1;
          if (csum_phase) begin
            state   <= ST_HEADER;
            hdr_idx <= '0;
          end
        end
        ST_HEADER: begin
          if (tx_rdy) begin
            if (hdr_idx == LAST_HDR) begin
              state   <= ST_PAYLOAD;
              hdr_idx <= '0;
              pay_idx <= '0;
            end else begin
              hdr_idx <= hdr_idx + 6'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (in_valid && tx_rdy) begin
            if (pay_idx == LAST_PAY) begin
              state     <= ST_IDLE;
              ident     <= ident + 16'd1;
              pkt_count <= pkt_count + 16'd1;
            end else begin
              pay_idx <= pay_idx + 11'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_data  = '0;
    tx_wren  = 1'b0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    in_ready = 1'b0;
    case (state)
      ST_HEADER: begin
        tx_wren = 1'b1;
        tx_data = hdr[LAST_HDR - hdr_idx];
        tx_sop  = (hdr_idx == 6'd0);
      end
      ST_PAYLOAD: begin
        tx_wren  = in_valid;
        tx_data  = in_data;
        in_ready = tx_rdy;
        tx_eop   = in_valid && (pay_idx == LAST_PAY);
      end
      default: ;
    endcase
  end

  assign tx_err = 1'b0;
  assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_udp_tx_framer.sv
// tb/tb_udp_tx_framer.sv - randomized self-checking bench for udp_tx_framer
module tb_udp_tx_framer;

  localparam int PLEN = 18;
  localparam int FLEN = 42 + PLEN;

  logic        tx_clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  tx_data;
  logic        tx_sop, tx_eop, tx_err, tx_wren;
  logic        tx_rdy;
  logic [15:0] pkt_count;
  logic        busy;

  udp_tx_framer #(.PAYLOAD_LEN(PLEN)) dut (
    .tx_clk    (tx_clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx_data   (tx_data),
    .tx_sop    (tx_sop),
    .tx_eop    (tx_eop),
    .tx_err    (tx_err),
    .tx_wren   (tx_wren),
    .tx_rdy    (tx_rdy),
    .pkt_count (pkt_count),
    .busy      (busy)
  );

  always #5 tx_clk = ~tx_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pay [4][PLEN];
  logic [7:0]  cur [FLEN];
  logic [7:0]  frm [4][FLEN];
  bit          drv_en = 0, rdy_rand = 0, b2b_chk = 0, started = 0;
  int          gap_at = -1;
  int          m_pos = 0, m_frame = 0, done = 0, since_eop = -1, gap_low = 0;
  logic [15:0] m_ident = 0, m_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame header written out field by field from the protocol definition.
  function automatic logic [7:0] exp_hdr(input int i, input logic [15:0] id);
    logic [15:0] w [10];
    logic [31:0] s;
    logic [15:0] cs, iplen, udplen;
    logic [7:0]  h [$];
    iplen  = 16'(28 + PLEN);
    udplen = 16'(8 + PLEN);
    w = '{16'h4500, iplen, id, 16'h4000, 16'h4011, 16'h0000,
          16'hC0A8, 16'h010A, 16'hC0A8, 16'h0101};
    s = 0;
    for (int j = 0; j < 10; j++) s += 32'(w[j]);
    while (s[31:16] != 0) s = 32'(s[15:0]) + 32'(s[31:16]);
    cs = ~s[15:0];
    h = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
         8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
         8'h08, 8'h00, 8'h45, 8'h00, iplen[15:8], iplen[7:0],
         id[15:8], id[7:0], 8'h40, 8'h00, 8'd64, 8'd17, cs[15:8], cs[7:0],
         8'd192, 8'd168, 8'd1, 8'd10, 8'd192, 8'd168, 8'd1, 8'd1,
         8'h13, 8'h88, 8'h13, 8'h88, udplen[15:8], udplen[7:0], 8'h00, 8'h00};
    return h[i];
  endfunction

  // Stimulus driver: in_valid/in_data/tx_rdy, changed 1 time unit after each edge.
  initial begin
    int k, f, gap_left;
    bit gap_done, acc, r;
    k = 0; f = 0; gap_left = 0; gap_done = 0; acc = 0;
    in_valid = 0; in_data = 0; tx_rdy = 1;
    forever begin
      @(posedge tx_clk);
      r = !rstn;
      #1;
      if (r) begin
        k = 0; f = 0; gap_left = 0; gap_done = 0;
      end else if (acc) begin
        k++;
        if (k == PLEN) begin
          k = 0;
          f++;
        end
      end
      if (gap_at == k && !gap_done && drv_en) begin
        gap_left = 5;
        gap_done = 1;
      end
      in_valid = drv_en && (gap_left == 0);
      if (gap_left > 0) gap_left--;
      in_data = pay[f % 4][k];
      tx_rdy  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge tx_clk);
      acc = in_valid && in_ready;
    end
  end

  // Compare process: model position advances only on transfers.
  initial begin
    bit r;
    logic [7:0] e;
    forever begin
      @(posedge tx_clk);
      r = !rstn;
      @(negedge tx_clk);
      if (r) begin
        started = 1;
        chk("rst_wren", tx_wren, 0);
        chk("rst_sop", tx_sop, 0);
        chk("rst_eop", tx_eop, 0);
        chk("rst_err", tx_err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_pkt_count", pkt_count, 0);
        m_pos = 0; m_ident = 0; m_count = 0; m_frame = 0;
        done = 0; since_eop = -1; gap_low = 0;
      end else if (started) begin
        chk("tx_err", tx_err, 0);
        chk("pkt_count", pkt_count, m_count);
        if (m_pos < 42) begin
          chk("in_ready_hdr", in_ready, 0);
        end else begin
          chk("in_ready_pay", in_ready, tx_rdy);
          chk("wren_pay", tx_wren, in_valid);
          if (!tx_wren) gap_low++;
        end
        if (tx_wren) begin
          e = (m_pos < 42) ? exp_hdr(m_pos, m_ident) : pay[m_frame % 4][m_pos - 42];
          chk($sformatf("data[%0d]", m_pos), tx_data, e);
          chk("sop", tx_sop, m_pos == 0);
          chk("eop", tx_eop, m_pos == FLEN - 1);
          chk("busy_active", busy, 1);
          if (m_pos == 0 && since_eop >= 0 && b2b_chk) chk("idle_gap", since_eop, 3);
          if (m_pos == 0) since_eop = -1;
          if (tx_rdy) begin
            cur[m_pos] = tx_data;
            m_pos++;
            if (m_pos == FLEN) begin
              for (int j = 0; j < FLEN; j++) frm[done % 4][j] = cur[j];
              done++; m_frame++; m_ident++; m_count++;
              m_pos = 0; since_eop = 0;
            end
          end
        end else begin
          chk("sop_idle", tx_sop, 0);
          chk("eop_idle", tx_eop, 0);
          if (since_eop == 0) chk("busy_after_eop", busy, 0);
          if (since_eop >= 0) since_eop++;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge tx_clk);
    #1 rstn = 0;
    repeat (3) @(posedge tx_clk);
    #1 rstn = 1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (done < n && c < budget) begin
      @(negedge tx_clk);
      c++;
    end
    chk("frames_within_budget", done >= n, 1);
  endtask

  task automatic chk_hdr16(input string nm, input int fi, input int b, input logic [15:0] exp);
    chk(nm, {frm[fi][b], frm[fi][b+1]}, exp);
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < PLEN; j++) pay[i][j] = 8'($urandom);

    // Back-to-back frames, MAC always ready.
    do_reset();
    b2b_chk = 1; drv_en = 1;
    wait_frames(2, 400);
    chk("b2b_pkt_count", pkt_count, 2);
    chk("f0_byte0", frm[0][0], 8'hFF);
    chk_hdr16("f0_ip_len", 0, 16, 16'h002E);
    chk_hdr16("f0_ident", 0, 18, 16'h0000);
    chk_hdr16("f0_csum", 0, 24, 16'hB763);
    chk_hdr16("f0_udp_len", 0, 38, 16'h001A);
    chk_hdr16("f1_ident", 1, 18, 16'h0001);
    chk_hdr16("f1_csum", 1, 24, 16'hB762);
    b2b_chk = 0;

    // Random MAC back-pressure.
    drv_en = 0;
    do_reset();
    rdy_rand = 1; drv_en = 1;
    wait_frames(2, 1500);
    chk_hdr16("rdy_f0_csum", 0, 24, 16'hB763);
    chk_hdr16("rdy_f1_csum", 1, 24, 16'hB762);
    rdy_rand = 0;

    // Five-cycle input gap at payload byte 7.
    drv_en = 0; gap_at = 7;
    do_reset();
    drv_en = 1;
    wait_frames(1, 400);
    chk("gap_wren_low", gap_low, 5);
    chk("gap_byte7", frm[0][49], pay[0][7]);
    gap_at = -1;

    // Reset in the middle of the header.
    drv_en = 0;
    do_reset();
    drv_en = 1;
    begin
      int c = 0;
      while (!(m_pos == 20 && dut.tx_wren) && c < 200) begin
        @(negedge tx_clk);
        c++;
      end
      chk("reached_hdr20", c < 200, 1);
    end
    @(posedge tx_clk);
    #1 rstn = 0;
    @(posedge tx_clk);
    #1 rstn = 1;
    wait_frames(1, 400);
    chk("rst_f0_byte0", frm[0][0], 8'hFF);
    chk_hdr16("rst_f0_ident", 0, 18, 16'h0000);
    chk("rst_pkt_count", pkt_count, 1);

    // ident preloaded to 0xFFFF wraps to 0x0000.
    drv_en = 0;
    do_reset();
    @(negedge tx_clk);
    force dut.ident = 16'hFFFF;
    m_ident = 16'hFFFF;
    @(posedge tx_clk);
    #1 release dut.ident;
    drv_en = 1;
    wait_frames(2, 400);
    chk_hdr16("wrap_f0_ident", 0, 18, 16'hFFFF);
    chk_hdr16("wrap_f0_csum", 0, 24, 16'hB763);
    chk_hdr16("wrap_f1_ident", 1, 18, 16'h0000);
    chk_hdr16("wrap_f1_csum", 1, 24, 16'hB763);
    chk("wrap_pkt_count", pkt_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
